// File: rtl/fp_pkg.sv
// Shared definitions for the modular-reduction issuer.
//   W          operand / residue width
//   P          field modulus (must match the reduction unit)
//   fp_op_e    request opcode encoding
//   fp_state_e issuer FSM states
//   fp_normalise  folds a residue of P (or above) back into [0, P-1]
package fp_pkg;

    localparam int W = 64;
    localparam logic [W-1:0] P = 64'd10997031918897188677;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_RED = 2'd3
    } fp_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } fp_state_e;

    // The reduction unit reports exact negative multiples of P as P itself.
    function automatic logic [W-1:0] fp_normalise(input logic [W-1:0] r);
        return (r >= P) ? (r - P) : r;
    endfunction

endpackage

// File: rtl/fp_shiftadd_mul.sv
// Sequential W x W -> 2W radix-2 shift-add multiplier, one multiplier bit per
// cycle, LSB first. A start pulse loads the operands; the multiplier then runs
// for exactly W cycles. done is high during the last step and product carries
// the completed result in that same cycle (it is the accumulator's next value).
//   clk, rst_n  clock, synchronous active-low reset
//   start       load x, y and begin
//   x, y        unsigned operands
//   done        high in the final step cycle
//   product     full 2W-bit product, valid while done is high
module fp_shiftadd_mul
    import fp_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W);

    logic           busy;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc_next;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = busy && (cnt == CW'(W - 1));
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            mcand  <= {{W{1'b0}}, x};
            mplier <= y;
            acc    <= '0;
            cnt    <= '0;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_mod_issuer.sv
// Initiator side of the 128-bit modular-reduction interface. Accepts a field
// operation on two W-bit operands, forms the 2W-bit two's-complement value,
// issues it to the reduction unit, waits for done, normalises the residue and
// returns it on a valid/ready response port.
//   clk, rst_n                         clock, synchronous active-low reset
//   req_valid/req_ready/req_op/x/y     request port (ready only in IDLE)
//   rsp_valid/rsp_ready/rsp_data       response port, residue in [0, P-1]
//   mod_enable/mod_a/mod_a_sign        start pulse and value to the reducer
//   mod_done/mod_result                completion pulse and raw residue
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a request
// S_MUL   | shift-add multiplier running (W cycles)
// S_ISSUE | mod_enable high for this single cycle
// S_WAIT  | waiting for the reducer's done pulse
// S_RESP  | residue presented until the consumer takes it
module fp_mod_issuer
    import fp_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [1:0]     req_op,
    input  logic [W-1:0]   req_x,
    input  logic [W-1:0]   req_y,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic           mod_enable,
    output logic [2*W-1:0] mod_a,
    output logic           mod_a_sign,
    input  logic           mod_done,
    input  logic [W-1:0]   mod_result
);

    fp_state_e      state, state_d;
    logic           a_load;
    logic [2*W-1:0] a_d;
    logic           rsp_load;
    logic           mul_start;
    logic           mul_done;
    logic [2*W-1:0] mul_product;
    logic [W:0]     sum;
    logic [W:0]     diff;

    // 65-bit add/sub; diff[W] is the borrow, i.e. the sign of x - y.
    assign sum  = {1'b0, req_x} + {1'b0, req_y};
    assign diff = {1'b0, req_x} - {1'b0, req_y};

    fp_shiftadd_mul u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .x       (req_x),
        .y       (req_y),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d    = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mod_enable = 1'b0;
        a_load     = 1'b0;
        a_d        = mod_a;
        rsp_load   = 1'b0;
        mul_start  = 1'b0;

        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    unique case (fp_op_e'(req_op))
                        OP_ADD: begin
                            a_load  = 1'b1;
                            a_d     = {{(W-1){1'b0}}, sum};
                            state_d = S_ISSUE;
                        end
                        OP_SUB: begin
                            a_load  = 1'b1;
                            a_d     = {{(W-1){diff[W]}}, diff};
                            state_d = S_ISSUE;
                        end
                        OP_RED: begin
                            // Top bit forced clear: only a 2W-1-bit magnitude is reduced.
                            a_load  = 1'b1;
                            a_d     = {1'b0, req_x[W-2:0], req_y};
                            state_d = S_ISSUE;
                        end
                        OP_MUL: begin
                            mul_start = 1'b1;
                            state_d   = S_MUL;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    a_load  = 1'b1;
                    a_d     = mul_product;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mod_enable = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (mod_done) begin
                    rsp_load = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mod_a    <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_d;
            if (a_load) begin
                mod_a <= a_d;
            end
            if (rsp_load) begin
                rsp_data <= fp_normalise(mod_result);
            end
        end
    end

    assign mod_a_sign = mod_a[2*W-1];

    // A product reaching bit 2W-1 would be misread as negative by the reducer.
    a_mul_sign_collision: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state == S_MUL && mul_done) |-> !mul_product[2*W-1]
    );

endmodule

// File: tb/tb_fp_mod_issuer.sv
module tb_fp_mod_issuer;

    localparam int          TW = 64;
    localparam logic [63:0] PM = 64'd10997031918897188677;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [63:0]  req_x;
    logic [63:0]  req_y;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [63:0]  rsp_data;
    logic         mod_enable;
    logic [127:0] mod_a;
    logic         mod_a_sign;
    logic         mod_done;
    logic [63:0]  mod_result;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fp_mod_issuer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_x      (req_x),
        .req_y      (req_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .mod_enable (mod_enable),
        .mod_a      (mod_a),
        .mod_a_sign (mod_a_sign),
        .mod_done   (mod_done),
        .mod_result (mod_result)
    );

    // ---------------- reference model ----------------
    function automatic logic [127:0] model_value(input logic [1:0] op,
                                                 input logic [63:0] x,
                                                 input logic [63:0] y);
        logic [127:0] xw, yw, r;
        xw = {64'd0, x};
        yw = {64'd0, y};
        case (op)
            2'd0:    r = xw + yw;
            2'd1:    r = xw - yw;
            2'd2:    r = xw * yw;
            default: r = (xw << 64) + yw;
        endcase
        if (op == 2'd3) r[127] = 1'b0;
        return r;
    endfunction

    function automatic logic [63:0] true_residue(input logic [127:0] v);
        logic [127:0] mag, rm;
        if (v[127]) begin
            mag = -v;
            rm  = mag % {64'd0, PM};
            return (rm == 0) ? 64'd0 : (PM - rm[63:0]);
        end
        rm = v % {64'd0, PM};
        return rm[63:0];
    endfunction

    // What the reduction unit returns: P instead of 0 for negative multiples.
    function automatic logic [63:0] unit_residue(input logic [127:0] v);
        logic [63:0] t;
        t = true_residue(v);
        return (v[127] && t == 64'd0) ? PM : t;
    endfunction

    // ---------------- drivers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [1:0] op, input logic [63:0] x,
                            input logic [63:0] y, output bit ok);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        ok = req_ready;
        req_valid = 1'b1;
        req_op    = op;
        req_x     = x;
        req_y     = y;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_enable(output int cyc, output bit ok);
        cyc = 1;
        while (!mod_enable && cyc < 200) begin
            tick();
            cyc++;
        end
        ok = mod_enable;
    endtask

    task automatic pulse_done(input logic [63:0] r);
        mod_done   = 1'b1;
        mod_result = r;
        tick();
        mod_done   = 1'b0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({req_ready, rsp_valid, mod_enable, mod_a_sign} !== 4'b1000 || rsp_data !== 64'd0 || mod_a !== 128'd0)
            $display("FAIL reset_values: rdy/vld/en/sign=%b%b%b%b data=%0h a=%0h required 1000/0/0",
                     req_ready, rsp_valid, mod_enable, mod_a_sign, rsp_data, mod_a);
        else n_pass++;
    endtask

    task automatic test_add();
        bit ok, ok2;
        int cyc;
        send_req(2'd0, 64'd5, 64'd7, ok);
        wait_enable(cyc, ok2);
        n_checks++;
        if (!(ok && ok2) || cyc !== 1) $display("FAIL add_latency: got %0d required 1", cyc);
        else n_pass++;
        n_checks++;
        if (mod_a !== 128'd12 || mod_a_sign !== 1'b0)
            $display("FAIL add_mod_a: got %0h sign %b required c sign 0", mod_a, mod_a_sign);
        else n_pass++;
        tick();
        n_checks++;
        if (mod_enable !== 1'b0 || mod_a !== 128'd12)
            $display("FAIL add_enable_pulse: en=%b a=%0h required en=0 a=c", mod_enable, mod_a);
        else n_pass++;
        pulse_done(64'd12);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 64'd12)
            $display("FAIL add_rsp: valid=%b data=%0d required 1/12", rsp_valid, rsp_data);
        else n_pass++;
        take_rsp();
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL add_return_idle: valid=%b ready=%b required 0/1", rsp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_sub();
        bit ok, ok2;
        int cyc;
        send_req(2'd1, 64'd3, 64'd10, ok);
        wait_enable(cyc, ok2);
        n_checks++;
        if (!(ok && ok2) || mod_a !== {{124{1'b1}}, 4'h9} || mod_a_sign !== 1'b1)
            $display("FAIL sub_neg_mod_a: got %0h sign %b required fff..f9 sign 1", mod_a, mod_a_sign);
        else n_pass++;
        tick();
        pulse_done(PM - 64'd7);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 64'd10997031918897188670)
            $display("FAIL sub_neg_rsp: got %0d required 10997031918897188670", rsp_data);
        else n_pass++;
        take_rsp();
        send_req(2'd1, 64'd9, 64'd9, ok);
        wait_enable(cyc, ok2);
        n_checks++;
        if (!(ok && ok2) || mod_a !== 128'd0 || mod_a_sign !== 1'b0)
            $display("FAIL sub_equal: got %0h sign %b required 0 sign 0", mod_a, mod_a_sign);
        else n_pass++;
        tick();
        pulse_done(64'd0);
        take_rsp();
    endtask

    task automatic test_mul_latency();
        bit ok, ok2;
        int cyc;
        send_req(2'd2, 64'h4000_0000_0000_0000, 64'd4, ok);
        wait_enable(cyc, ok2);
        n_checks++;
        if (!(ok && ok2) || cyc !== TW + 1) $display("FAIL mul_latency: got %0d required %0d", cyc, TW + 1);
        else n_pass++;
        n_checks++;
        if (mod_a !== (128'd1 << 64) || mod_a_sign !== 1'b0)
            $display("FAIL mul_mod_a: got %0h sign %b required 1_0000000000000000 sign 0", mod_a, mod_a_sign);
        else n_pass++;
        tick();
        pulse_done(unit_residue(128'd1 << 64));
        n_checks++;
        if (rsp_data !== true_residue(128'd1 << 64))
            $display("FAIL mul_rsp: got %0d required %0d", rsp_data, true_residue(128'd1 << 64));
        else n_pass++;
        take_rsp();
    endtask

    task automatic test_normalise();
        bit ok, ok2;
        int cyc;
        send_req(2'd1, 64'd0, PM, ok);
        wait_enable(cyc, ok2);
        n_checks++;
        if (!(ok && ok2) || mod_a !== -{64'd0, PM} || mod_a_sign !== 1'b1)
            $display("FAIL minus_p_mod_a: got %0h sign %b required -P sign 1", mod_a, mod_a_sign);
        else n_pass++;
        tick();
        pulse_done(PM);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 64'd0)
            $display("FAIL normalise_p: got %0d required 0", rsp_data);
        else n_pass++;
        take_rsp();
    endtask

    task automatic test_backpressure();
        bit ok, ok2;
        int cyc;
        send_req(2'd0, 64'd100, 64'd200, ok);
        wait_enable(cyc, ok2);
        tick();
        pulse_done(64'd300);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_op    = 2'd0;
            req_x     = 64'd1;
            req_y     = 64'd1;
            if (i == 2) begin
                mod_done   = 1'b1;
                mod_result = 64'd999;
            end
            tick();
            mod_done = 1'b0;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 64'd300 || req_ready !== 1'b0)
                $display("FAIL backpressure_hold[%0d]: valid=%b data=%0d ready=%b required 1/300/0",
                         i, rsp_valid, rsp_data, req_ready);
            else n_pass++;
        end
        req_valid = 1'b0;
        take_rsp();
        tick();
        n_checks++;
        if (req_ready !== 1'b1 || mod_enable !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL backpressure_release: ready=%b en=%b valid=%b required 1/0/0",
                     req_ready, mod_enable, rsp_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        bit ok, ok2;
        int cyc;
        send_req(2'd0, 64'd40, 64'd2, ok);
        wait_enable(cyc, ok2);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({req_ready, rsp_valid, mod_enable, mod_a_sign} !== 4'b1000 || rsp_data !== 64'd0 || mod_a !== 128'd0)
            $display("FAIL reset_mid_wait: rdy/vld/en/sign=%b%b%b%b data=%0h a=%0h required 1000/0/0",
                     req_ready, rsp_valid, mod_enable, mod_a_sign, rsp_data, mod_a);
        else n_pass++;
        pulse_done(64'd42);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 64'd0)
            $display("FAIL late_done_ignored: valid=%b ready=%b data=%0d required 0/1/0",
                     rsp_valid, req_ready, rsp_data);
        else n_pass++;
        send_req(2'd0, 64'd1, 64'd1, ok);
        wait_enable(cyc, ok2);
        tick();
        pulse_done(64'd2);
        n_checks++;
        if (!(ok && ok2) || rsp_valid !== 1'b1 || rsp_data !== 64'd2)
            $display("FAIL post_reset_add: valid=%b data=%0d required 1/2", rsp_valid, rsp_data);
        else n_pass++;
        take_rsp();
    endtask

    task automatic test_random();
        bit ok, ok2;
        int cyc, want_cyc;
        logic [1:0]   op;
        logic [63:0]  x, y;
        logic [127:0] want_a;
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            x  = {$urandom, $urandom};
            y  = {$urandom, $urandom};
            if (op == 2'd2) begin
                x[63] = 1'b0;
                y[63] = 1'b0;
            end
            if (op == 2'd3) x[63] = 1'b0;
            want_a   = model_value(op, x, y);
            want_cyc = (op == 2'd2) ? TW + 1 : 1;
            send_req(op, x, y, ok);
            wait_enable(cyc, ok2);
            n_checks++;
            if (!(ok && ok2) || cyc !== want_cyc || mod_a !== want_a || mod_a_sign !== want_a[127])
                $display("FAIL rand_issue[%0d] op=%0d: lat=%0d a=%0h sign=%b required lat=%0d a=%0h sign=%b",
                         i, op, cyc, mod_a, mod_a_sign, want_cyc, want_a, want_a[127]);
            else n_pass++;
            tick();
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
            pulse_done(unit_residue(want_a));
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== true_residue(want_a) || mod_a !== want_a)
                $display("FAIL rand_rsp[%0d] op=%0d: valid=%b data=%0d required 1/%0d",
                         i, op, rsp_valid, rsp_data, true_residue(want_a));
            else n_pass++;
            for (int d = 0; d < int'($urandom_range(0, 2)); d++) tick();
            take_rsp();
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'd0;
        req_x      = 64'd0;
        req_y      = 64'd0;
        rsp_ready  = 1'b0;
        mod_done   = 1'b0;
        mod_result = 64'd0;
        test_reset();
        test_add();
        test_sub();
        test_mul_latency();
        test_normalise();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
